csr_machine_file: RTL and testbench

Parametrised machine-mode CSR file and trap unit for the CPU-X core, sitting beside the execute stage. It provides CSR read-modify-write access for the CSRRW/CSRRS/CSRRC families and takes synchronous exceptions and the three machine interrupts. It handles MRET and supplies redirect PCs to fetch. Generalises the fixed 32-bit field set to XLEN 32/64 and adds vectored trap dispatch plus 64-bit mcycle/minstret counters with mcountinhibit.

---
 rtl/csr_pkg.sv | 43 ++++
 rtl/csr_machine_file_counter64.sv | 29 ++
 rtl/csr_machine_file.sv | 217 +++++++++++++++++++++
 tb/tb_csr_machine_file.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR definitions for the CPU-X machine-mode CSR file.
// Addresses, operation encoding and XLEN-parametric mcause helpers.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_WRITE = 2'b01,
    CSR_SET   = 2'b10,
    CSR_CLEAR = 2'b11
  } csr_op_t;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MSTATUSH      = 12'h310;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  localparam logic [4:0] IRQ_MSI = 5'd3;
  localparam logic [4:0] IRQ_MTI = 5'd7;
  localparam logic [4:0] IRQ_MEI = 5'd11;

  function automatic int mcause_int_bit(input int xlen);
    return xlen - 1;
  endfunction

  function automatic logic [63:0] mcause_int_mask(input int xlen);
    return 64'd1 << mcause_int_bit(xlen);
  endfunction

endpackage

// File: rtl/csr_machine_file_counter64.sv
// 64-bit event counter with inhibit and split/full write ports.
// Any write takes precedence over the increment for the whole counter.
module csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inhibit,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic        we_full,
  input  logic [63:0] wdata,
  output logic [63:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (we_full) begin
      value <= wdata;
    end else if (we_lo) begin
      value[31:0] <= wdata[31:0];
    end else if (we_hi) begin
      value[63:32] <= wdata[31:0];
    end else if (inc && !inhibit) begin
      value <= value + 64'd1;
    end
  end

endmodule

// File: rtl/csr_machine_file.sv
// Machine-mode CSR file and trap unit beside the execute stage.
// Handles CSR RMW, exceptions, interrupts, MRET and fetch redirects.
module csr_machine_file
  import csr_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] HART_ID     = '0,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            csr_en,
  input  csr_op_t         csr_op,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            inst_retired,
  input  logic            exc_valid,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  output logic            int_req,
  input  logic            int_ack,
  input  logic [XLEN-1:0] int_pc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam bit X32 = (XLEN == 32);
  localparam logic [XLEN-1:0] ALIGN = XLEN'(3);
  localparam logic [XLEN-1:0] INT_BIT =
    XLEN'(mcause_int_mask(XLEN));
  localparam logic [XLEN-1:0] MXL =
    X32 ? XLEN'(1) : XLEN'(2);
  localparam logic [XLEN-1:0] MISA =
    (MXL << (XLEN - 2)) | XLEN'(32'h1100);

  logic            st_mie, st_mpie;
  logic [2:0]      ie;
  logic            cy_inh, ir_inh;
  logic [XLEN-1:0] mtvec_r, mscratch_r;
  logic [XLEN-1:0] mepc_r, mcause_r, mtval_r;
  logic [63:0]     cyc, ins;

  logic [2:0]      ip, pend;
  logic [4:0]      int_code;
  logic [XLEN-1:0] rdata, nv;
  logic [XLEN-1:0] trap_base, int_target;
  logic            impl, wr;
  logic [63:0]     cnt_wdata;

  assign ip   = {irq_ext, irq_timer, irq_soft};
  assign pend = ip & ie;
  assign int_req = st_mie & (|pend);

  always_comb begin
    int_code = IRQ_MTI;
    if (pend[2])      int_code = IRQ_MEI;
    else if (pend[0]) int_code = IRQ_MSI;
  end

  assign trap_base  = mtvec_r & ~ALIGN;
  assign int_target = mtvec_r[0]
    ? trap_base + (XLEN'(int_code) << 2)
    : trap_base;

  always_comb begin
    rdata = '0;
    impl  = 1'b1;
    case (csr_addr)
      CSR_MISA:      rdata = MISA;
      CSR_MVENDORID,
      CSR_MARCHID,
      CSR_MIMPID:    rdata = '0;
      CSR_MHARTID:   rdata = HART_ID;
      CSR_MSTATUS:
        rdata = XLEN'({2'b11, 3'b0, st_mpie,
                       3'b0, st_mie, 3'b0});
      CSR_MSTATUSH:  impl = X32;
      CSR_MTVEC:     rdata = mtvec_r;
      CSR_MIE:
        rdata = XLEN'({ie[2], 3'b0, ie[1],
                       3'b0, ie[0], 3'b0});
      CSR_MIP:
        rdata = XLEN'({ip[2], 3'b0, ip[1],
                       3'b0, ip[0], 3'b0});
      CSR_MSCRATCH:  rdata = mscratch_r;
      CSR_MEPC:      rdata = mepc_r;
      CSR_MCAUSE:    rdata = mcause_r;
      CSR_MTVAL:     rdata = mtval_r;
      CSR_MCOUNTINHIBIT:
        rdata = XLEN'({ir_inh, 1'b0, cy_inh});
      CSR_MCYCLE:    rdata = cyc[XLEN-1:0];
      CSR_MINSTRET:  rdata = ins[XLEN-1:0];
      CSR_MCYCLEH: begin
        rdata = X32 ? XLEN'(cyc[63:32]) : '0;
        impl  = X32;
      end
      CSR_MINSTRETH: begin
        rdata = X32 ? XLEN'(ins[63:32]) : '0;
        impl  = X32;
      end
      default:       impl = 1'b0;
    endcase
  end

  assign csr_rdata   = rdata;
  assign csr_illegal = csr_en &
    (~impl | ((csr_addr[11:10] == 2'b11) & csr_we));

  always_comb begin
    case (csr_op)
      CSR_WRITE: nv = csr_wdata;
      CSR_SET:   nv = rdata | csr_wdata;
      CSR_CLEAR: nv = rdata & ~csr_wdata;
      default:   nv = rdata;
    endcase
  end

  // Any trap or MRET in the same cycle swallows the CSR write
  assign wr = csr_en & csr_we & ~csr_illegal &
              ~(exc_valid | int_ack | mret);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      st_mie         <= 1'b0;
      st_mpie        <= 1'b0;
      ie             <= '0;
      cy_inh         <= 1'b0;
      ir_inh         <= 1'b0;
      mtvec_r        <= MTVEC_RESET;
      mscratch_r     <= '0;
      mepc_r         <= '0;
      mcause_r       <= '0;
      mtval_r        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      if (exc_valid) begin
        mepc_r         <= exc_pc & ~ALIGN;
        mcause_r       <= XLEN'(exc_cause);
        mtval_r        <= exc_tval;
        st_mpie        <= st_mie;
        st_mie         <= 1'b0;
        redirect_valid <= 1'b1;
        redirect_pc    <= trap_base;
      end else if (int_ack) begin
        mepc_r         <= int_pc & ~ALIGN;
        mcause_r       <= INT_BIT | XLEN'(int_code);
        mtval_r        <= '0;
        st_mpie        <= st_mie;
        st_mie         <= 1'b0;
        redirect_valid <= 1'b1;
        redirect_pc    <= int_target;
      end else if (mret) begin
        st_mie         <= st_mpie;
        st_mpie        <= 1'b1;
        redirect_valid <= 1'b1;
        redirect_pc    <= mepc_r;
      end else if (wr) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            st_mie  <= nv[3];
            st_mpie <= nv[7];
          end
          CSR_MTVEC:
            mtvec_r <= {nv[XLEN-1:2],
                        nv[1] ? mtvec_r[1:0] : nv[1:0]};
          CSR_MIE:      ie <= {nv[11], nv[7], nv[3]};
          CSR_MSCRATCH: mscratch_r <= nv;
          CSR_MEPC:     mepc_r <= nv & ~ALIGN;
          CSR_MCAUSE:   mcause_r <= nv;
          CSR_MTVAL:    mtval_r <= nv;
          CSR_MCOUNTINHIBIT: begin
            cy_inh <= nv[0];
            ir_inh <= nv[2];
          end
          default: ;
        endcase
      end
    end
  end

  assign cnt_wdata = 64'(nv);

  csr_counter64 u_mcycle (
    .clk     (CLK),
    .rst_n   (nRST),
    .inhibit (cy_inh),
    .inc     (1'b1),
    .we_lo   (X32 && wr && csr_addr == CSR_MCYCLE),
    .we_hi   (wr && csr_addr == CSR_MCYCLEH),
    .we_full (!X32 && wr && csr_addr == CSR_MCYCLE),
    .wdata   (cnt_wdata),
    .value   (cyc)
  );

  csr_counter64 u_minstret (
    .clk     (CLK),
    .rst_n   (nRST),
    .inhibit (ir_inh),
    .inc     (inst_retired),
    .we_lo   (X32 && wr && csr_addr == CSR_MINSTRET),
    .we_hi   (wr && csr_addr == CSR_MINSTRETH),
    .we_full (!X32 && wr && csr_addr == CSR_MINSTRET),
    .wdata   (cnt_wdata),
    .value   (ins)
  );

endmodule

// File: tb/tb_csr_machine_file.sv
// Directed self-checking bench for csr_machine_file (XLEN=32).
// Hand-computed expectations checked with immediate assertions.
module tb_csr_machine_file;
  import csr_pkg::*;

  logic        CLK, nRST;
  logic        csr_en, csr_we;
  csr_op_t     csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        csr_illegal, inst_retired;
  logic        exc_valid, mret;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval;
  logic        irq_ext, irq_timer, irq_soft;
  logic        int_req, int_ack;
  logic [31:0] int_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int total = 0;
  int bad = 0;
  logic [31:0] rd;
  logic        ill;

  csr_machine_file #(
    .XLEN        (32),
    .HART_ID     (32'd5),
    .MTVEC_RESET (32'h100)
  ) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .csr_en         (csr_en),
    .csr_op         (csr_op),
    .csr_we         (csr_we),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_illegal    (csr_illegal),
    .inst_retired   (inst_retired),
    .exc_valid      (exc_valid),
    .exc_cause      (exc_cause),
    .exc_pc         (exc_pc),
    .exc_tval       (exc_tval),
    .mret           (mret),
    .irq_ext        (irq_ext),
    .irq_timer      (irq_timer),
    .irq_soft       (irq_soft),
    .int_req        (int_req),
    .int_ack        (int_ack),
    .int_pc         (int_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic csr(input csr_op_t op,
                     input logic [11:0] a,
                     input logic [31:0] wd,
                     input logic we);
    csr_en = 1'b1;
    csr_op = op;
    csr_addr = a;
    csr_wdata = wd;
    csr_we = we;
    #1;
    rd = csr_rdata;
    ill = csr_illegal;
    step();
    csr_en = 1'b0;
    csr_we = 1'b0;
  endtask

  task automatic rdc(input logic [11:0] a);
    csr(CSR_SET, a, 32'h0, 1'b0);
  endtask

  task automatic wrc(input logic [11:0] a,
                     input logic [31:0] wd);
    csr(CSR_WRITE, a, wd, 1'b1);
  endtask

  initial begin
    nRST = 1'b0;
    csr_en = 0; csr_we = 0; csr_op = CSR_WRITE;
    csr_addr = '0; csr_wdata = '0;
    inst_retired = 0; exc_valid = 0; mret = 0;
    exc_cause = '0; exc_pc = '0; exc_tval = '0;
    irq_ext = 0; irq_timer = 0; irq_soft = 0;
    int_ack = 0; int_pc = '0;
    #2;
    chk("rst_rv", redirect_valid, 0);
    chk("rst_rpc", redirect_pc, 0);
    chk("rst_ireq", int_req, 0);
    #10 nRST = 1'b1;
    step();

    rdc(CSR_MISA);
    chk("misa", rd, 32'h40001100);
    chk("misa_ill", ill, 0);
    rdc(CSR_MTVEC);
    chk("mtvec_rst", rd, 32'h100);
    rdc(CSR_MHARTID);
    chk("hartid", rd, 5);

    csr(CSR_SET, CSR_MSTATUS, 32'h8, 1'b1);
    chk("mstatus_s", rd, 32'h1800);
    csr(CSR_CLEAR, CSR_MSTATUS, 32'h8, 1'b1);
    chk("mstatus_c", rd, 32'h1808);
    rdc(CSR_MSTATUS);
    chk("mstatus_r", rd, 32'h1800);

    wrc(CSR_MHARTID, 32'h77);
    chk("ro_ill", ill, 1);
    rdc(CSR_MHARTID);
    chk("ro_keep", rd, 5);
    chk("ro_rd_ok", ill, 0);
    rdc(12'h7C0);
    chk("unimpl", ill, 1);
    rdc(CSR_MSTATUSH);
    chk("mstatush", rd, 0);

    wrc(CSR_MSCRATCH, 32'hA5);
    rdc(CSR_MSCRATCH);
    chk("mscratch", rd, 32'hA5);
    wrc(CSR_MEPC, 32'h123);
    rdc(CSR_MEPC);
    chk("mepc_warl", rd, 32'h120);
    wrc(CSR_MTVEC, 32'h1003);
    rdc(CSR_MTVEC);
    chk("mtvec_m3", rd, 32'h1000);

    wrc(CSR_MTVEC, 32'h1001);
    rdc(CSR_MTVEC);
    chk("mtvec", rd, 32'h1001);
    wrc(CSR_MIE, 32'h80);
    irq_timer = 1'b1;
    #1;
    chk("ireq_off", int_req, 0);
    csr(CSR_SET, CSR_MSTATUS, 32'h8, 1'b1);
    chk("ireq_on", int_req, 1);
    rdc(CSR_MIP);
    chk("mip", rd, 32'h80);

    int_ack = 1'b1;
    int_pc = 32'h200;
    step();
    int_ack = 1'b0;
    chk("int_rv", redirect_valid, 1);
    chk("int_rpc", redirect_pc, 32'h101C);
    chk("int_drop", int_req, 0);
    rdc(CSR_MCAUSE);
    chk("int_cause", rd, 32'h80000007);
    chk("rv_pulse", redirect_valid, 0);
    rdc(CSR_MEPC);
    chk("int_mepc", rd, 32'h200);
    rdc(CSR_MSTATUS);
    chk("int_mst", rd, 32'h1880);
    rdc(CSR_MTVAL);
    chk("int_tval", rd, 0);

    irq_timer = 1'b0;
    mret = 1'b1;
    step();
    mret = 1'b0;
    chk("mret_rv", redirect_valid, 1);
    chk("mret_rpc", redirect_pc, 32'h200);
    rdc(CSR_MSTATUS);
    chk("mret_mst", rd, 32'h1888);

    exc_valid = 1'b1;
    exc_cause = 5'd2;
    exc_pc = 32'h40;
    exc_tval = 32'hDEAD;
    int_ack = 1'b1;
    int_pc = 32'h300;
    mret = 1'b1;
    csr_en = 1'b1;
    csr_we = 1'b1;
    csr_op = CSR_WRITE;
    csr_addr = CSR_MSCRATCH;
    csr_wdata = 32'h55;
    step();
    exc_valid = 0; int_ack = 0; mret = 0;
    csr_en = 0; csr_we = 0;
    chk("exc_rv", redirect_valid, 1);
    chk("exc_rpc", redirect_pc, 32'h1000);
    rdc(CSR_MCAUSE);
    chk("exc_cause", rd, 2);
    rdc(CSR_MEPC);
    chk("exc_mepc", rd, 32'h40);
    rdc(CSR_MTVAL);
    chk("exc_tval", rd, 32'hDEAD);
    rdc(CSR_MSTATUS);
    chk("exc_mst", rd, 32'h1880);
    rdc(CSR_MSCRATCH);
    chk("exc_drop_wr", rd, 32'hA5);

    wrc(CSR_MCYCLEH, 32'h0);
    wrc(CSR_MCYCLE, 32'hFFFFFFFF);
    rdc(CSR_MCYCLE);
    chk("cyc_ff", rd, 32'hFFFFFFFF);
    rdc(CSR_MCYCLE);
    chk("cyc_wrap", rd, 0);
    rdc(CSR_MCYCLEH);
    chk("cyc_carry", rd, 1);

    wrc(CSR_MCOUNTINHIBIT, 32'hFF);
    rdc(CSR_MCOUNTINHIBIT);
    chk("inh_warl", rd, 5);
    wrc(CSR_MCYCLE, 32'h1234);
    rdc(CSR_MCYCLE);
    chk("cyc_inh0", rd, 32'h1234);
    rdc(CSR_MCYCLE);
    chk("cyc_inh1", rd, 32'h1234);

    wrc(CSR_MINSTRET, 32'h0);
    wrc(CSR_MCOUNTINHIBIT, 32'h1);
    inst_retired = 1; step();
    inst_retired = 0; step();
    inst_retired = 1; step();
    step();
    inst_retired = 0; step();
    rdc(CSR_MINSTRET);
    chk("minstret", rd, 3);
    rdc(CSR_MINSTRETH);
    chk("minstreth", rd, 0);

    exc_valid = 1'b1;
    exc_cause = 5'd4;
    #2 nRST = 1'b0;
    step();
    chk("nrst_rv", redirect_valid, 0);
    chk("nrst_rpc", redirect_pc, 0);
    chk("nrst_ireq", int_req, 0);
    exc_valid = 1'b0;
    nRST = 1'b1;
    step();
    rdc(CSR_MTVEC);
    chk("nrst_mtvec", rd, 32'h100);
    rdc(CSR_MSTATUS);
    chk("nrst_mst", rd, 32'h1800);
    rdc(CSR_MEPC);
    chk("nrst_mepc", rd, 0);
    rdc(CSR_MCAUSE);
    chk("nrst_cause", rd, 0);
    rdc(CSR_MSCRATCH);
    chk("nrst_scr", rd, 0);
    rdc(CSR_MCOUNTINHIBIT);
    chk("nrst_inh", rd, 0);
    chk("nrst_rv2", redirect_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
